// File: rtl/exec_mem_unit_if.sv
// Operand, control and result bundle between the decode/operand-mux side
// and the execute/memory stage.
interface exec_mem_if;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_o;
  logic [6:0]  op_code;
  logic [2:0]  br_type;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        br_en;
  logic        mem_wr;
  logic        mem_rd;
  logic [2:0]  mask;
  logic [31:0] dmem_o;

  modport master (
    output alu_a, alu_b, alu_op, op_code, br_type, rs1_data, rs2_data,
           mem_wr, mem_rd, mask,
    input  alu_o, br_en, dmem_o
  );

  modport slave (
    input  alu_a, alu_b, alu_op, op_code, br_type, rs1_data, rs2_data,
           mem_wr, mem_rd, mask,
    output alu_o, br_en, dmem_o
  );
endinterface

// File: rtl/exec_mem_unit.sv
// RV32I execute/memory stage: combinational ALU, branch decision and a
// byte-addressed little-endian data memory with combinational loads.
module exec_mem_unit #(
  parameter int DEPTH = 256
) (
  input logic        clk,
  input logic        rst,
  exec_mem_if.slave  mem_bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLL  = 4'd2,
    OP_SLT  = 4'd3,
    OP_SLTU = 4'd4,
    OP_XOR  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_OR   = 4'd8,
    OP_AND  = 4'd9,
    OP_LUI  = 4'd10
  } alu_op_e;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [4:0]  w_shamt;
  logic [31:0] w_alu_o;

  assign w_a     = mem_bus.alu_a;
  assign w_b     = mem_bus.alu_b;
  assign w_shamt = w_b[4:0];

  // ---------------------------------------------------------------- ALU
  // NOTE: combinational blocks use blocking '=' and assign a default first,
  // so every path drives the output and no latch is inferred.
  always_comb begin
    w_alu_o = '0;
    case (alu_op_e'(mem_bus.alu_op))
      OP_ADD:  w_alu_o = w_a + w_b;
      OP_SUB:  w_alu_o = w_a - w_b;
      OP_SLL:  w_alu_o = w_a << w_shamt;
      OP_SLT:  w_alu_o = {31'd0, $signed(w_a) < $signed(w_b)};
      OP_SLTU: w_alu_o = {31'd0, w_a < w_b};
      OP_XOR:  w_alu_o = w_a ^ w_b;
      OP_SRL:  w_alu_o = w_a >> w_shamt;
      OP_SRA:  w_alu_o = 32'($signed(w_a) >>> w_shamt);
      OP_OR:   w_alu_o = w_a | w_b;
      OP_AND:  w_alu_o = w_a & w_b;
      OP_LUI:  w_alu_o = w_b;
      default: w_alu_o = '0;
    endcase
  end

  assign mem_bus.alu_o = w_alu_o;

  // ------------------------------------------------------- branch decision
  logic w_eq;
  logic w_lt;
  logic w_ltu;
  logic w_br_en;

  assign w_eq  = (mem_bus.rs1_data == mem_bus.rs2_data);
  assign w_lt  = ($signed(mem_bus.rs1_data) < $signed(mem_bus.rs2_data));
  assign w_ltu = (mem_bus.rs1_data < mem_bus.rs2_data);

  always_comb begin
    w_br_en = 1'b0;
    if (mem_bus.op_code == OPC_JAL || mem_bus.op_code == OPC_JALR) begin
      w_br_en = 1'b1;
    end else if (mem_bus.op_code == OPC_BRANCH) begin
      case (mem_bus.br_type)
        3'b000:  w_br_en = w_eq;
        3'b001:  w_br_en = !w_eq;
        3'b100:  w_br_en = w_lt;
        3'b101:  w_br_en = !w_lt;
        3'b110:  w_br_en = w_ltu;
        3'b111:  w_br_en = !w_ltu;
        default: w_br_en = 1'b0;
      endcase
    end
  end

  assign mem_bus.br_en = w_br_en;

  // ---------------------------------------------------------- data memory
  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] w_idx;
  logic [1:0]    w_lane;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic          w_unused_addr;

  // Addresses wrap modulo 4*DEPTH: the bits above the word index are dropped.
  assign w_idx         = w_alu_o[AW+1:2];
  assign w_lane        = w_alu_o[1:0];
  assign w_unused_addr = ^w_alu_o[31:AW+2];

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = mem_bus.rs2_data;
    case (mem_bus.mask[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{mem_bus.rs2_data[7:0]}};
      end
      2'b01: begin
        w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{mem_bus.rs2_data[15:0]}};
      end
      default: ;
    endcase
  end

  // NOTE: the memory is cleared by the asynchronous reset, so it maps to
  // resettable flops rather than a RAM macro; sequential state uses '<='.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (mem_bus.mem_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
    end
  end

  // -------------------------------------------------------------- loads
  logic [31:0] w_word;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_dmem_o;

  assign w_word = r_mem[w_idx];
  assign w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    case (w_lane)
      2'd0:    w_byte = w_word[7:0];
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase
  end

  always_comb begin
    w_dmem_o = '0;
    if (mem_bus.mem_rd) begin
      case (mem_bus.mask)
        3'b000:  w_dmem_o = {{24{w_byte[7]}}, w_byte};
        3'b100:  w_dmem_o = {24'd0, w_byte};
        3'b001:  w_dmem_o = {{16{w_half[15]}}, w_half};
        3'b101:  w_dmem_o = {16'd0, w_half};
        default: w_dmem_o = w_word;
      endcase
    end
  end

  assign mem_bus.dmem_o = w_dmem_o;

endmodule

// File: tb/tb_exec_mem_unit.sv
// Directed bench for exec_mem_unit: ALU, branch decision, loads/stores,
// address wrap, asynchronous memory clear and same-cycle read/write.
module tb_exec_mem_unit;

  localparam int DEPTH = 256;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;

  exec_mem_if bus ();

  exec_mem_unit #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .mem_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_vec++;
    assert (observed === expected)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic set_alu(input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op);
    bus.alu_a  = a;
    bus.alu_b  = b;
    bus.alu_op = op;
  endtask

  task automatic load(input logic [31:0] addr, input logic [2:0] m);
    set_alu(addr, 32'd0, 4'd0);
    bus.mask   = m;
    bus.mem_rd = 1'b1;
    bus.mem_wr = 1'b0;
    #1;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data,
                       input logic [2:0] m);
    @(negedge clk);
    set_alu(addr, 32'd0, 4'd0);
    bus.rs2_data = data;
    bus.mask     = m;
    bus.mem_wr   = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_wr = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst          = 1'b0;
    bus.alu_a    = '0;
    bus.alu_b    = '0;
    bus.alu_op   = '0;
    bus.op_code  = '0;
    bus.br_type  = '0;
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    bus.mem_wr   = 1'b0;
    bus.mem_rd   = 1'b1;
    bus.mask     = 3'b010;
    #12;
    check("reset_load0", bus.dmem_o, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    load(32'h10, 3'b010);
    check("post_reset_load10", bus.dmem_o, 32'h0);

    // ALU
    set_alu(32'h7FFFFFFF, 32'd1, 4'd0);  #1; check("add_ovf", bus.alu_o, 32'h80000000);
    set_alu(32'd5, 32'd7, 4'd1);         #1; check("sub", bus.alu_o, 32'hFFFFFFFE);
    set_alu(32'hFFFFFFFF, 32'd1, 4'd3);  #1; check("slt", bus.alu_o, 32'd1);
    set_alu(32'hFFFFFFFF, 32'd1, 4'd4);  #1; check("sltu", bus.alu_o, 32'd0);
    set_alu(32'h80000000, 32'd4, 4'd7);  #1; check("sra", bus.alu_o, 32'hF8000000);
    set_alu(32'h80000000, 32'd4, 4'd6);  #1; check("srl", bus.alu_o, 32'h08000000);
    set_alu(32'h1, 32'h23, 4'd2);        #1; check("sll_shamt5", bus.alu_o, 32'h8);
    set_alu(32'hF0F0F0F0, 32'hFF00FF00, 4'd5); #1; check("xor", bus.alu_o, 32'h0FF00FF0);
    set_alu(32'hF0F0F0F0, 32'h0F000F00, 4'd8); #1; check("or", bus.alu_o, 32'hFFF0FFF0);
    set_alu(32'hF0F0F0F0, 32'hFF00FF00, 4'd9); #1; check("and", bus.alu_o, 32'hF000F000);
    set_alu(32'h0, 32'h12345000, 4'd10); #1; check("lui", bus.alu_o, 32'h12345000);
    set_alu(32'h5, 32'h7, 4'd11);        #1; check("op11_zero", bus.alu_o, 32'h0);
    set_alu(32'h5, 32'h7, 4'd15);        #1; check("op15_zero", bus.alu_o, 32'h0);

    // Branch decision
    bus.rs1_data = 32'hFFFFFFFF;
    bus.rs2_data = 32'd1;
    bus.op_code  = 7'b1100011;
    bus.br_type = 3'b100; #1; check("blt", {31'd0, bus.br_en}, 32'd1);
    bus.br_type = 3'b110; #1; check("bltu", {31'd0, bus.br_en}, 32'd0);
    bus.br_type = 3'b000; #1; check("beq", {31'd0, bus.br_en}, 32'd0);
    bus.br_type = 3'b001; #1; check("bne", {31'd0, bus.br_en}, 32'd1);
    bus.br_type = 3'b101; #1; check("bge", {31'd0, bus.br_en}, 32'd0);
    bus.br_type = 3'b111; #1; check("bgeu", {31'd0, bus.br_en}, 32'd1);
    bus.br_type = 3'b010; #1; check("br_type010", {31'd0, bus.br_en}, 32'd0);
    bus.op_code = 7'b1101111; #1; check("jal", {31'd0, bus.br_en}, 32'd1);
    bus.op_code = 7'b1100111; bus.br_type = 3'b011; #1;
    check("jalr", {31'd0, bus.br_en}, 32'd1);
    bus.op_code = 7'b0110011; bus.br_type = 3'b001; #1;
    check("rtype_no_branch", {31'd0, bus.br_en}, 32'd0);

    // Word store and sub-word loads
    store(32'h10, 32'hDEADBEEF, 3'b010);
    load(32'h10, 3'b010); check("lw_10", bus.dmem_o, 32'hDEADBEEF);
    load(32'h13, 3'b000); check("lb_13", bus.dmem_o, 32'hFFFFFFDE);
    load(32'h13, 3'b100); check("lbu_13", bus.dmem_o, 32'h000000DE);
    load(32'h10, 3'b001); check("lh_10", bus.dmem_o, 32'hFFFFBEEF);
    load(32'h12, 3'b101); check("lhu_12", bus.dmem_o, 32'h0000DEAD);
    load(32'h11, 3'b001); check("lh_11_ignores_a0", bus.dmem_o, 32'hFFFFBEEF);
    load(32'h12, 3'b111); check("mask111_as_lw", bus.dmem_o, 32'hDEADBEEF);

    // Partial stores
    store(32'h11, 32'h000000AA, 3'b000);
    load(32'h10, 3'b010); check("sb_11", bus.dmem_o, 32'hDEADAAEF);
    store(32'h12, 32'h00001234, 3'b001);
    load(32'h10, 3'b010); check("sh_12", bus.dmem_o, 32'h1234AAEF);

    // mem_rd low gives zero
    bus.mem_rd = 1'b0; #1;
    check("rd_low_zero", bus.dmem_o, 32'h0);

    // Address wrap
    store(32'(4 * DEPTH + 8), 32'h00000055, 3'b010);
    load(32'h8, 3'b010); check("wrap_lw8", bus.dmem_o, 32'h00000055);

    // Same-cycle read and write
    store(32'h20, 32'h11111111, 3'b010);
    @(negedge clk);
    set_alu(32'h20, 32'd0, 4'd0);
    bus.mask     = 3'b010;
    bus.rs2_data = 32'h22222222;
    bus.mem_rd   = 1'b1;
    bus.mem_wr   = 1'b1;
    #1;
    check("rdwr_before_edge", bus.dmem_o, 32'h11111111);
    @(posedge clk);
    #1;
    bus.mem_wr = 1'b0;
    check("rdwr_after_edge", bus.dmem_o, 32'h22222222);

    // Mid-cycle asynchronous reset
    load(32'h8, 3'b010);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("async_clear_lw8", bus.dmem_o, 32'h0);
    load(32'h10, 3'b010); check("async_clear_lw10", bus.dmem_o, 32'h0);
    set_alu(32'h3, 32'h4, 4'd0); #1;
    check("alu_during_reset", bus.alu_o, 32'h7);

    // Store under reset is discarded
    @(negedge clk);
    set_alu(32'h8, 32'd0, 4'd0);
    bus.rs2_data = 32'h77777777;
    bus.mask     = 3'b010;
    bus.mem_wr   = 1'b1;
    @(posedge clk);
    #1;
    check("store_in_reset", bus.dmem_o, 32'h0);
    @(negedge clk);
    bus.mem_wr = 1'b0;
    rst = 1'b1;
    #1;
    check("after_reset_lw8", bus.dmem_o, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/exec_mem_unit.md
Name: exec_mem_unit

Overview:
Execute/memory stage of the single-cycle RV32I core: combinational ALU, branch/jump decision unit and byte-addressed data memory. The data memory address is the ALU result; its store data is rs2_data. br_en drives the PC-select mux: 1 selects alu_o as the next PC, 0 selects PC+4. The block sits between the operand muxes / main control and the write-back mux.

Parameters:
DEPTH, 256, number of 32-bit data-memory words (1 KiB); must be a power of two.

Ports:
clk  in  1  system clock; memory writes occur on the rising edge
rst  in  1  asynchronous reset, active-low (asserted at 0); clears the data memory
alu_a  in  32  ALU operand A (rs1 or PC)
alu_b  in  32  ALU operand B (rs2 or immediate)
alu_op  in  4  ALU operation select
alu_o  out  32  ALU result; also the data-memory byte address
op_code  in  7  instruction bits [6:0]
br_type  in  3  branch condition (funct3 encoding)
rs1_data  in  32  register rs1 value, used for branch compare
rs2_data  in  32  register rs2 value, used for branch compare and as store data
br_en  out  1  1 = take branch/jump target (alu_o)
mem_wr  in  1  store enable
mem_rd  in  1  load enable
mask  in  3  access size/sign (funct3 encoding)
dmem_o  out  32  load result, extended to 32 bits

Behaviour:
- ALU (combinational). alu_op encoding:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT (signed), 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 pass B (LUI).
  - alu_op 11-15 give 0.
  - Shift amount is b[4:0]. Add/sub wrap modulo 2^32. SLT/SLTU return 0 or 1.
- Branch control (combinational):
  - op_code 1100011 (branch): br_type 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU; br_type 010/011 give br_en=0.
  - op_code 1101111 (JAL) or 1100111 (JALR): br_en=1 regardless of br_type.
  - Any other op_code: br_en=0.
- Data memory: DEPTH x 32-bit words, little-endian.
  - Word index = alu_o[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*DEPTH.
- Stores: on posedge clk when mem_wr=1 and rst=1.
  - mask[1:0]=00 byte: write rs2_data[7:0] to the byte lane addr[1:0].
  - mask[1:0]=01 half: write rs2_data[15:0] to lanes {addr[1],0} and {addr[1],1}.
  - Otherwise word: write the full word; addr[1:0] ignored.
  - Other bytes of the word are unchanged.
- Loads: combinational read; dmem_o=0 when mem_rd=0.
  - mask 000 LB sign-extend, 100 LBU zero-extend, 001 LH sign-extend, 101 LHU zero-extend, 010 LW.
  - mask 011/110/111 are treated as LW.
  - Halfword accesses use addr[1] and ignore addr[0]; no misalignment trap.
- Same-cycle read and write to one address: dmem_o shows the old data until the clock edge, then the new data.
- mem_wr and mem_rd may be high together; the write still occurs.
- Reset:
  - rst=0 immediately clears every memory word to 0, independent of clk.
  - A store in the same cycle as reset is discarded.
  - During and after reset, dmem_o=0 for any load until a store occurs.
  - alu_o and br_en are pure functions of their inputs and are unaffected by reset.
- Latency: ALU, branch and load are zero-cycle combinational; a store is visible to loads from the cycle after its clock edge.

Test Plan:
- ALU: a=0x7FFFFFFF, b=1, ADD -> 0x80000000. a=5, b=7, SUB -> 0xFFFFFFFE. a=0xFFFFFFFF, b=1: SLT -> 1, SLTU -> 0. a=0x80000000, b=4, SRA -> 0xF8000000; SRL -> 0x08000000. alu_op 10 with b=0x12345000 -> 0x12345000.
- Branch: op_code 1100011 with rs1=0xFFFFFFFF, rs2=1 -> br_type 100 gives 1, br_type 110 gives 0, 000 gives 0, 001 gives 1. op_code 1101111 with any br_type -> 1. op_code 0110011 -> 0.
- Store/load word: SW 0xDEADBEEF at addr 0x10 (mask 010), then mem_rd at 0x10 -> 0xDEADBEEF. Next cycle LB 0x13 -> 0xFFFFFFDE, LBU 0x13 -> 0x000000DE, LH 0x10 -> 0xFFFFBEEF, LHU 0x12 -> 0x0000DEAD.
- Partial stores: SB 0xAA at 0x11 over word 0xDEADBEEF -> LW 0x10 = 0xDEADAAEF. SH 0x1234 at 0x12 -> LW 0x10 = 0x1234AAEF.
- Wrap and reset: SW 0x55 at addr 4*DEPTH+8 -> LW at 8 = 0x55. Assert rst=0 mid-cycle -> LW 8 = 0 immediately. A store attempted while rst=0 leaves the word at 0.
- mem_rd=0 with a valid address -> dmem_o=0. mem_rd and mem_wr both high at one address -> dmem_o shows the old value before the edge and the new value after it.
